// File: rtl/prog_delay_line.sv
// prog_delay_line: runtime-programmable delay line counted in valid samples, with a circular RAM and fill masking
module prog_delay_line #(
   parameter int WIDTH     = 16,
   parameter int MAX_DELAY = 64,
   parameter int DLY_W     = $clog2(MAX_DELAY + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_load,
   input  logic [DLY_W-1:0] delay_cfg,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [DLY_W-1:0] cur_delay,
   output logic             cfg_err
);
   localparam int AW = MAX_DELAY > 1 ? $clog2(MAX_DELAY) : 1;
   typedef enum logic {FILL, RUN} state_t;
   state_t           state, state_eff;
   logic [WIDTH-1:0] mem [MAX_DELAY];
   logic [AW-1:0]    wr_ptr, rd_addr;
   logic [DLY_W-1:0] fill, fill_eff, d_cfg, d_eff;
   logic [DLY_W:0]   rd_sum;
   logic             emit;
   // a load in this cycle takes effect for the sample arriving with it
   always_comb begin
      d_cfg     = delay_cfg > DLY_W'(MAX_DELAY) ? DLY_W'(MAX_DELAY) : delay_cfg;
      d_eff     = cfg_load ? d_cfg : cur_delay;
      fill_eff  = cfg_load ? '0 : fill;
      state_eff = cfg_load ? FILL : state;
      emit      = din_valid && (state_eff == RUN || fill_eff == d_eff);
      rd_sum    = (DLY_W+1)'(wr_ptr) + (DLY_W+1)'(MAX_DELAY) - (DLY_W+1)'(d_eff);
      rd_addr   = AW'(rd_sum >= (DLY_W+1)'(MAX_DELAY) ? rd_sum - (DLY_W+1)'(MAX_DELAY) : rd_sum);
   end
   always_ff @(posedge clk)
      if (din_valid) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         cur_delay  <= '0;
         cfg_err    <= 1'b0;
         wr_ptr     <= '0;
         fill       <= '0;
         state      <= FILL;
      end else begin
         if (cfg_load) begin
            cur_delay <= d_cfg;
            cfg_err   <= cfg_err | (delay_cfg > DLY_W'(MAX_DELAY));
         end
         dout_valid <= emit;
         if (emit) dout <= d_eff == '0 ? din : mem[rd_addr];
         if (din_valid) wr_ptr <= wr_ptr == AW'(MAX_DELAY - 1) ? '0 : wr_ptr + AW'(1);
         fill  <= din_valid && state_eff == FILL ? fill_eff + DLY_W'(1) : fill_eff;
         state <= emit ? RUN : state_eff;
      end
endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: random and directed stimulus checked against a sample-queue model of the delay line
module tb_prog_delay_line;
   localparam int WIDTH = 16;
   localparam int MAXD  = 64;
   localparam int DLY_W = $clog2(MAXD + 1);
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_load = 1'b0;
   logic [DLY_W-1:0] delay_cfg = '0;
   logic [WIDTH-1:0] din = '0;
   logic             din_valid = 1'b0;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic [DLY_W-1:0] cur_delay;
   logic             cfg_err;
   int checks = 0;
   int errors = 0;
   bit run_cmp = 0;
   logic [WIDTH-1:0] hist[$];
   int               md = 0;
   logic             e_dv = 0;
   logic [WIDTH-1:0] e_dout = '0;
   logic             e_err = 0;
   prog_delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAXD)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .delay_cfg(delay_cfg),
      .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid),
      .cur_delay(cur_delay), .cfg_err(cfg_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      hist.delete();
      md = 0; e_dv = 0; e_dout = '0; e_err = 0;
   endtask
   // output is the sample D places back among those accepted since the last flush
   task automatic model_step(input bit load, input int cfg, input bit v, input logic [WIDTH-1:0] d);
      if (load) begin
         md = cfg > MAXD ? MAXD : cfg;
         e_err = e_err | (cfg > MAXD);
         hist.delete();
      end
      e_dv = 0;
      if (v) begin
         hist.push_back(d);
         if (hist.size() > md) begin
            e_dv = 1;
            e_dout = hist[hist.size() - 1 - md];
         end
         if (hist.size() > MAXD + 1) void'(hist.pop_front());
      end
   endtask
   task automatic step(input bit load, input int cfg, input bit v, input logic [WIDTH-1:0] d);
      @(negedge clk);
      #1;
      cfg_load = load; delay_cfg = DLY_W'(cfg); din_valid = v; din = d;
      @(posedge clk);
      model_step(load, cfg, v, d);
   endtask
   task automatic do_reset();
      @(negedge clk);
      #2;
      cfg_load = 0; din_valid = 0; rst_n = 0;
      #1;
      model_reset();
      @(negedge clk);
      #2;
      rst_n = 1;
   endtask
   always @(negedge clk)
      if (run_cmp && rst_n) begin
         chk("dout_valid", dout_valid, e_dv);
         chk("dout", dout, e_dout);
         chk("cur_delay", cur_delay, md);
         chk("cfg_err", cfg_err, e_err);
      end
   initial begin
      do_reset();
      run_cmp = 1;
      chk("rst_dout", dout, 0);
      chk("rst_cur_delay", cur_delay, 0);
      step(0, 0, 1, 16'hA5A5); #1;
      chk("t4_noload_dv", dout_valid, 1);
      chk("t4_noload_dout", dout, 16'hA5A5);
      step(1, 3, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         step(0, 0, 1, WIDTH'(i)); #1;
         if (i == 3) chk("t1_prime_dv", dout_valid, 0);
         if (i == 4) begin chk("t1_first_dv", dout_valid, 1); chk("t1_first", dout, 1); end
         if (i == 6) chk("t1_third", dout, 3);
      end
      step(1, 3, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 1, WIDTH'(i)); #1;
         if (i == 4) chk("t2_first", dout, 1);
         step(0, 0, 0, 16'hFFFF); #1;
         if (i == 4) begin chk("t2_gap_dv", dout_valid, 0); chk("t2_gap_hold", dout, 1); end
      end
      step(1, 64, 0, 0);
      for (int k = 0; k < 200; k++) begin
         step(0, 0, 1, WIDTH'(k)); #1;
         if (k == 63) chk("t3_prime_dv", dout_valid, 0);
         if (k == 64) begin chk("t3_first_dv", dout_valid, 1); chk("t3_first", dout, 0); end
         if (k == 199) chk("t3_last", dout, 135);
      end
      step(1, 0, 1, 16'hA5A5); #1;
      chk("t4_d0_dv", dout_valid, 1);
      chk("t4_d0", dout, 16'hA5A5);
      step(1, 5, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, WIDTH'(100 + i));
      step(1, 2, 1, 500); #1;
      chk("t5_load_dv", dout_valid, 0);
      step(0, 0, 1, 501); #1;
      chk("t5_next_dv", dout_valid, 0);
      step(0, 0, 1, 502); #1;
      chk("t5_third_dv", dout_valid, 1);
      chk("t5_third", dout, 500);
      step(1, 100, 0, 0); #1;
      chk("t6_clamp", cur_delay, 64);
      chk("t6_err", cfg_err, 1);
      step(1, 4, 0, 0); #1;
      chk("t6_sticky", cfg_err, 1);
      chk("t6_cur4", cur_delay, 4);
      for (int i = 0; i < 8; i++) step(0, 0, 1, WIDTH'(i + 7));
      @(negedge clk);
      #2;
      cfg_load = 0; din_valid = 0; rst_n = 0;
      #1;
      chk("t6_async_dout", dout, 0);
      chk("t6_async_dv", dout_valid, 0);
      chk("t6_async_err", cfg_err, 0);
      model_reset();
      @(negedge clk);
      #2;
      rst_n = 1;
      for (int n = 0; n < 3000; n++) begin
         if (n % 700 == 699) do_reset();
         step($urandom_range(0, 39) == 0, int'($urandom_range(0, 80)),
              $urandom_range(0, 9) < 7, WIDTH'($urandom));
      end
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
